result_writeback: RTL
=====================

Name: result_writeback

Overview:
Downstream stage of the multiply-accumulate core (datapath + controller). It captures each finished 32-bit result (c_data_out) on the rising edge of the core's done flag and buffers it in a small FIFO. It then drains the results to a memory write port using a valid/ready handshake, at consecutive addresses from a programmed base. It reports when the programmed number of results has been written.

Parameters:
DATA_W, 32, width of result word and memory write data
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 16, width of memory address and result count

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  one-cycle pulse; arms a job (ignored unless idle)
base_addr  input  ADDR_W  first write address, sampled on accepted start
count  input  ADDR_W  number of results in job, sampled on accepted start
res_data  input  DATA_W  result word from core (c_data_out)
res_done  input  1  core done flag (level or pulse)
mem_wr_valid  output  1  write request valid
mem_wr_addr  output  ADDR_W  write address
mem_wr_data  output  DATA_W  write data
mem_wr_ready  input  1  memory accepts write this cycle
busy  output  1  job in progress (state != IDLE)
fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: a result was dropped
all_done  output  1  one-cycle pulse, job complete

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, all counters 0, res_done_q=0. All outputs 0. Mid-job reset discards FIFO contents; mem_wr_valid drops immediately.
- Edge detect: res_done_q <= res_done every cycle, in all states. capture = res_done & ~res_done_q. A done level already high before start is never captured.
- States: IDLE, RUN, FLUSH, FIN.
- IDLE, start=1: latch base_addr into wr_addr and count into target. Clear captured, written and overflow.
  - count!=0: go RUN.
  - count==0: go FIN directly; all_done is high the next cycle, with no writes.
- IDLE, start=0: hold. Captures in IDLE are ignored and do not set overflow.
- RUN, capture=1:
  - Push res_data if (!full || pop this cycle); captured++.
  - Otherwise drop the word and set overflow=1 (sticky until next accepted start). captured is not incremented.
- RUN: when captured reaches target (including via this cycle's push), go FLUSH.
- FLUSH: captures ignored and not flagged. When FIFO empty and no write pending, go FIN.
- FIN: all_done=1 for exactly this cycle, then IDLE.
- start while busy: ignored, no side effects.
- Write handshake:
  - mem_wr_valid = FIFO non-empty and state in {RUN, FLUSH}.
  - mem_wr_data = FIFO head; mem_wr_addr = wr_addr.
  - All three stay stable while valid && !ready.
  - Transfer on valid && ready: pop, wr_addr++ (wraps mod 2^ADDR_W), written++.
- Latency: a capture at edge t makes mem_wr_valid high during cycle t+1 if the FIFO was empty. Throughput is one write per cycle with ready held high.
- Simultaneous push and pop: allowed in any state with occupancy unchanged, including full (push accepted because the pop frees a slot).
- fifo_level: 0..DEPTH, registered, updated on push/pop.
- captured and written are ADDR_W wide. target==2^ADDR_W-1 must complete without counter wrap.

Test Plan:
1. base_addr=0x0100, count=3, ready=1. Three res_done pulses with data 0x11, 0x22, 0x33 spaced 5 cycles apart -> writes (0x0100,0x11), (0x0101,0x22), (0x0102,0x33). Each valid rises 1 cycle after its capture. all_done pulses once; busy falls with it; overflow=0.
2. count=6, DEPTH=4, ready=0. Six done pulses 2 cycles apart -> fifo_level reaches 4; 5th and 6th dropped; overflow=1. Raise ready -> 4 writes, with the data stable while ready was low. Job stays in RUN, captured=4, no all_done. A further capture after the drain is accepted.
3. FIFO full with ready=1 and a capture in the same cycle -> push and pop both occur, fifo_level stays 4, no overflow, addresses strictly consecutive.
4. base_addr=0xFFFE, count=3 -> writes at 0xFFFE, 0xFFFF, 0x0000.
5. res_done held high before start, count=1 -> no capture until done falls and rises again. count=0 start -> all_done the cycle after start, no mem_wr_valid.
6. rst=0 while 2 entries are buffered and valid is high -> valid, busy and fifo_level go to 0 asynchronously. After release, a new start with count=1 writes exactly one word at the new base.

Source files
------------

// File: rtl/result_writeback.sv
// Result write-back stage: captures MAC results on the rising edge of the core's
// done flag, buffers them in a small FIFO and drains them to a memory write port.
module result_writeback #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ADDR_W-1:0]          count,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       res_done,
  output logic                       mem_wr_valid,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [DATA_W-1:0]          mem_wr_data,
  input  logic                       mem_wr_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       all_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FIN} state_t;

  state_t              state_q, state_d;
  logic                res_done_q;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [ADDR_W-1:0]   captured_q, captured_d;
  logic [ADDR_W-1:0]   written_q, written_d;
  logic                overflow_q, overflow_d;
  logic [LW-1:0]       level_q, level_d;
  logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0]   fifo_q [DEPTH];

  logic                capture, full, push, pop;
  logic [ADDR_W-1:0]   captured_inc;

  assign capture      = res_done & ~res_done_q;
  assign full         = (level_q == LW'(DEPTH));
  assign mem_wr_valid = (level_q != '0) && ((state_q == S_RUN) || (state_q == S_FLUSH));
  assign pop          = mem_wr_valid & mem_wr_ready;
  assign captured_inc = captured_q + 1'b1;

  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = fifo_q[rd_ptr_q];
  assign busy         = (state_q != S_IDLE);
  assign fifo_level   = level_q;
  assign overflow     = overflow_q;
  assign all_done     = (state_q == S_FIN);

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    target_d   = target_q;
    captured_d = captured_q;
    written_d  = written_q;
    overflow_d = overflow_q;
    push       = 1'b0;

    if (pop) begin
      wr_addr_d = wr_addr_q + 1'b1;
      written_d = written_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_addr_d  = base_addr;
          target_d   = count;
          captured_d = '0;
          written_d  = '0;
          overflow_d = 1'b0;
          state_d    = (count == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (capture) begin
          // a pop in the same cycle frees the slot, so a full FIFO can still accept
          if (!full || pop) begin
            push       = 1'b1;
            captured_d = captured_inc;
            if (captured_inc == target_q) state_d = S_FLUSH;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (level_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      res_done_q <= 1'b0;
      wr_addr_q  <= '0;
      target_q   <= '0;
      captured_q <= '0;
      written_q  <= '0;
      overflow_q <= 1'b0;
      level_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      res_done_q <= res_done;
      wr_addr_q  <= wr_addr_d;
      target_q   <= target_d;
      captured_q <= captured_d;
      written_q  <= written_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= res_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule
